// File: rtl/vga_timing_pkg.sv
// Shared timing record, VGA 640x480 defaults and per-axis derivation helpers.
// Record fields are TF_W wide so one type serves any axis up to TF_W-1 bits.
package vga_timing_pkg;

  localparam int unsigned TF_W = 16;

  typedef logic [TF_W-1:0] tfield_t;

  typedef struct packed {
    tfield_t h_view, h_front, h_sync, h_back;
    tfield_t v_view, v_front, v_sync, v_back;
  } timing_t;

  localparam int VGA_H_VIEW  = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BACK  = 48;
  localparam int VGA_V_VIEW  = 480;
  localparam int VGA_V_FRONT = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BACK  = 33;

  function automatic tfield_t axis_max(input tfield_t view, front, sync, back);
    return view + front + sync + back - tfield_t'(1);
  endfunction

  function automatic tfield_t sync_lo(input tfield_t view, front);
    return view + front;
  endfunction

  // Exclusive end; equals the axis total when back porch is 0.
  function automatic tfield_t sync_hi(input tfield_t view, front, sync);
    return view + front + sync;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus blank/sync decode registered
// from the next position, so the decoded flags line up with pos_o.
module vga_axis_counter #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] max_i,
  input  logic [W:0]   view_i,
  input  logic [W:0]   sync_lo_i,
  input  logic [W:0]   sync_hi_i,
  output logic [W-1:0] pos_o,
  output logic         wrap_o,
  output logic         blank_o,
  output logic         sync_o,
  output logic         blank_nxt_o
);

  logic [W-1:0] pos_q, pos_d;
  logic [W:0]   pos_ext;
  logic         blank_q, blank_d, sync_q, sync_d;

  assign wrap_o = en_i && (pos_q == max_i);

  // view/sync bounds describe the timing in force after this edge
  always_comb begin
    pos_d = pos_q;
    if (en_i) pos_d = wrap_o ? '0 : pos_q + W'(1);
    pos_ext = {1'b0, pos_d};
    blank_d = pos_ext >= view_i;
    sync_d  = (pos_ext >= sync_lo_i) && (pos_ext < sync_hi_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q   <= '0;
      blank_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
    end
  end

  assign pos_o       = pos_q;
  assign blank_o     = blank_q;
  assign sync_o      = sync_q;
  assign blank_nxt_o = blank_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-reprogrammable video timing generator; new timing is held in a
// shadow register and only becomes active at the frame wrap.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_BITS       = 10,
  parameter int V_BITS       = 10,
  parameter int H_VIEW       = VGA_H_VIEW,
  parameter int H_FRONT      = VGA_H_FRONT,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_BACK       = VGA_H_BACK,
  parameter int V_VIEW       = VGA_V_VIEW,
  parameter int V_FRONT      = VGA_V_FRONT,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_BACK       = VGA_V_BACK,
  parameter bit HSYNC_ACTIVE = 1'b1,
  parameter bit VSYNC_ACTIVE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [H_BITS-1:0] cfg_h_view,
  input  logic [H_BITS-1:0] cfg_h_front,
  input  logic [H_BITS-1:0] cfg_h_sync,
  input  logic [H_BITS-1:0] cfg_h_back,
  input  logic [V_BITS-1:0] cfg_v_view,
  input  logic [V_BITS-1:0] cfg_v_front,
  input  logic [V_BITS-1:0] cfg_v_sync,
  input  logic [V_BITS-1:0] cfg_v_back,
  output logic              cfg_err,
  output logic [H_BITS-1:0] hpos,
  output logic [V_BITS-1:0] vpos,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic              visible,
  output logic              line_start,
  output logic              frame_start
);

  localparam int HSW = H_BITS + 2;
  localparam int VSW = V_BITS + 2;
  localparam int H1W = H_BITS + 1;
  localparam int V1W = V_BITS + 1;
  localparam logic [HSW-1:0] H_LIM = {2'b01, {H_BITS{1'b0}}};
  localparam logic [VSW-1:0] V_LIM = {2'b01, {V_BITS{1'b0}}};
  localparam timing_t RST_TIMING = '{
    h_view: tfield_t'(H_VIEW), h_front: tfield_t'(H_FRONT),
    h_sync: tfield_t'(H_SYNC), h_back:  tfield_t'(H_BACK),
    v_view: tfield_t'(V_VIEW), v_front: tfield_t'(V_FRONT),
    v_sync: tfield_t'(V_SYNC), v_back:  tfield_t'(V_BACK)};

  timing_t          active_q, active_d, shadow_q, cfg_rec;
  logic             shadow_full_q, shadow_full_d;
  logic             cfg_err_q, line_start_q, frame_start_q, visible_q;
  logic [HSW-1:0]   h_sum;
  logic [VSW-1:0]   v_sum;
  logic             cfg_ok, accept, reject, apply;
  logic             h_wrap, v_wrap, v_en;
  logic             h_blank_nxt, v_blank_nxt, h_sync_int, v_sync_int;
  logic [H_BITS-1:0] h_max;
  logic [V_BITS-1:0] v_max;
  logic [H1W-1:0]   h_view_n, h_slo_n, h_shi_n;
  logic [V1W-1:0]   v_view_n, v_slo_n, v_shi_n;

  always_comb begin
    cfg_rec = '{
      h_view: tfield_t'(cfg_h_view), h_front: tfield_t'(cfg_h_front),
      h_sync: tfield_t'(cfg_h_sync), h_back:  tfield_t'(cfg_h_back),
      v_view: tfield_t'(cfg_v_view), v_front: tfield_t'(cfg_v_front),
      v_sync: tfield_t'(cfg_v_sync), v_back:  tfield_t'(cfg_v_back)};
    h_sum = HSW'(cfg_h_view) + HSW'(cfg_h_front) + HSW'(cfg_h_sync) + HSW'(cfg_h_back);
    v_sum = VSW'(cfg_v_view) + VSW'(cfg_v_front) + VSW'(cfg_v_sync) + VSW'(cfg_v_back);
    cfg_ok = (cfg_h_view != '0) && (cfg_h_sync != '0) &&
             (cfg_v_view != '0) && (cfg_v_sync != '0) &&
             (h_sum <= H_LIM) && (v_sum <= V_LIM);
  end

  assign accept = cfg_valid && !shadow_full_q && cfg_ok;
  assign reject = cfg_valid && !shadow_full_q && !cfg_ok;
  assign v_en   = pix_en && h_wrap;
  assign apply  = h_wrap && v_wrap && shadow_full_q;

  assign h_max = H_BITS'(axis_max(active_q.h_view, active_q.h_front,
                                  active_q.h_sync, active_q.h_back));
  assign v_max = V_BITS'(axis_max(active_q.v_view, active_q.v_front,
                                  active_q.v_sync, active_q.v_back));

  // Decode uses the timing that holds after this edge, so (0,0) of a freshly
  // applied frame already reflects the new mode.
  always_comb begin
    active_d      = apply ? shadow_q : active_q;
    shadow_full_d = shadow_full_q;
    if (apply)       shadow_full_d = 1'b0;
    else if (accept) shadow_full_d = 1'b1;
    h_view_n = H1W'(active_d.h_view);
    h_slo_n  = H1W'(sync_lo(active_d.h_view, active_d.h_front));
    h_shi_n  = H1W'(sync_hi(active_d.h_view, active_d.h_front, active_d.h_sync));
    v_view_n = V1W'(active_d.v_view);
    v_slo_n  = V1W'(sync_lo(active_d.v_view, active_d.v_front));
    v_shi_n  = V1W'(sync_hi(active_d.v_view, active_d.v_front, active_d.v_sync));
  end

  vga_axis_counter #(.W(H_BITS)) u_h_axis (
    .clk_i(clk), .rst_ni(reset), .en_i(pix_en), .max_i(h_max),
    .view_i(h_view_n), .sync_lo_i(h_slo_n), .sync_hi_i(h_shi_n),
    .pos_o(hpos), .wrap_o(h_wrap), .blank_o(hblank), .sync_o(h_sync_int),
    .blank_nxt_o(h_blank_nxt)
  );

  vga_axis_counter #(.W(V_BITS)) u_v_axis (
    .clk_i(clk), .rst_ni(reset), .en_i(v_en), .max_i(v_max),
    .view_i(v_view_n), .sync_lo_i(v_slo_n), .sync_hi_i(v_shi_n),
    .pos_o(vpos), .wrap_o(v_wrap), .blank_o(vblank), .sync_o(v_sync_int),
    .blank_nxt_o(v_blank_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q      <= RST_TIMING;
      shadow_full_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      visible_q     <= 1'b1;
    end else begin
      active_q      <= active_d;
      shadow_full_q <= shadow_full_d;
      cfg_err_q     <= reject;
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap && v_wrap;
      visible_q     <= !h_blank_nxt && !v_blank_nxt;
    end
  end

  // Shadow contents are only meaningful while shadow_full_q is set.
  always_ff @(posedge clk) begin
    if (accept) shadow_q <= cfg_rec;
  end

  assign cfg_ready   = !shadow_full_q;
  assign cfg_err     = cfg_err_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign visible     = visible_q;
  assign hsync       = HSYNC_ACTIVE ? h_sync_int : !h_sync_int;
  assign vsync       = VSYNC_ACTIVE ? v_sync_int : !v_sync_int;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800-clk lines with a short 8-line frame, plus a
// negative-polarity twin driven by the same stimulus.
module tb_vga_timing_gen;

  localparam int HB = 10;
  localparam int VB = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_en = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [HB-1:0] cfg_h_view, cfg_h_front, cfg_h_sync, cfg_h_back;
  logic [VB-1:0] cfg_v_view, cfg_v_front, cfg_v_sync, cfg_v_back;

  logic          cfg_ready, cfg_err, hsync, vsync, hblank, vblank, visible;
  logic          line_start, frame_start;
  logic [HB-1:0] hpos;
  logic [VB-1:0] vpos;

  logic          n_cfg_ready, n_cfg_err, n_hsync, n_vsync, n_hblank, n_vblank;
  logic          n_visible, n_line_start, n_frame_start;
  logic [HB-1:0] n_hpos;
  logic [VB-1:0] n_vpos;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_BITS(HB), .V_BITS(VB),
    .H_VIEW(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VIEW(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_view(cfg_h_view), .cfg_h_front(cfg_h_front),
    .cfg_h_sync(cfg_h_sync), .cfg_h_back(cfg_h_back),
    .cfg_v_view(cfg_v_view), .cfg_v_front(cfg_v_front),
    .cfg_v_sync(cfg_v_sync), .cfg_v_back(cfg_v_back),
    .cfg_err(cfg_err), .hpos(hpos), .vpos(vpos),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .visible(visible), .line_start(line_start), .frame_start(frame_start)
  );

  vga_timing_gen #(
    .H_BITS(HB), .V_BITS(VB),
    .H_VIEW(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VIEW(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0)
  ) dut_neg (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .cfg_valid(cfg_valid), .cfg_ready(n_cfg_ready),
    .cfg_h_view(cfg_h_view), .cfg_h_front(cfg_h_front),
    .cfg_h_sync(cfg_h_sync), .cfg_h_back(cfg_h_back),
    .cfg_v_view(cfg_v_view), .cfg_v_front(cfg_v_front),
    .cfg_v_sync(cfg_v_sync), .cfg_v_back(cfg_v_back),
    .cfg_err(n_cfg_err), .hpos(n_hpos), .vpos(n_vpos),
    .hsync(n_hsync), .vsync(n_vsync), .hblank(n_hblank), .vblank(n_vblank),
    .visible(n_visible), .line_start(n_line_start), .frame_start(n_frame_start)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Per-scan statistics
  int s_ls, s_fs, s_hs, s_vs, s_vis, s_hsn_lo, s_vsn_lo;
  int s_first_hs, s_first_vs, s_fs_t, s_ls_per, s_hbad, s_vbad, s_rdy_lo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int hv, hf, hs, hb, vv, vf, vs, vb);
    cfg_h_view = HB'(hv); cfg_h_front = HB'(hf); cfg_h_sync = HB'(hs); cfg_h_back = HB'(hb);
    cfg_v_view = VB'(vv); cfg_v_front = VB'(vf); cfg_v_sync = VB'(vs); cfg_v_back = VB'(vb);
  endtask

  // Runs n edges starting from raster index p0 of an hl x vl frame; with tog
  // set only odd-numbered edges carry pix_en.
  task automatic scan(input int n, input bit tog, input int p0, input int hl, input int vl);
    int e, idx, last_ls;
    s_ls = 0; s_fs = 0; s_hs = 0; s_vs = 0; s_vis = 0; s_hsn_lo = 0; s_vsn_lo = 0;
    s_first_hs = -1; s_first_vs = -1; s_fs_t = -1; s_ls_per = -1;
    s_hbad = 0; s_vbad = 0; s_rdy_lo = 0; last_ls = -1;
    for (int t = 1; t <= n; t++) begin
      pix_en = tog ? ((t % 2) == 1) : 1'b1;
      tick();
      e   = tog ? (t + 1) / 2 : t;
      idx = (p0 + e) % (hl * vl);
      if (int'(hpos) != idx % hl) s_hbad++;
      if (int'(vpos) != idx / hl) s_vbad++;
      if (line_start) begin
        s_ls++;
        if (last_ls >= 0) s_ls_per = t - last_ls;
        last_ls = t;
      end
      if (frame_start) begin s_fs++; s_fs_t = t; end
      if (hsync) begin s_hs++; if (s_first_hs < 0) s_first_hs = t; end
      if (vsync) begin s_vs++; if (s_first_vs < 0) s_first_vs = t; end
      if (visible) s_vis++;
      if (!n_hsync) s_hsn_lo++;
      if (!n_vsync) s_vsn_lo++;
      if (!cfg_ready) s_rdy_lo++;
    end
    pix_en = 1'b1;
  endtask

  initial begin
    set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
    #2 reset = 1'b0;
    tick(); tick();
    check("rst_hpos", hpos, 0);
    check("rst_vpos", vpos, 0);
    check("rst_hsync", hsync, 0);
    check("rst_vsync", vsync, 0);
    check("rst_hsync_neg", n_hsync, 1);
    check("rst_vsync_neg", n_vsync, 1);
    check("rst_blank", {hblank, vblank}, 0);
    check("rst_visible", visible, 1);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_strobes", {cfg_err, line_start, frame_start}, 0);

    reset  = 1'b1;
    pix_en = 1'b1;
    scan(639, 1'b0, 0, 800, 8);
    check("h639_hpos", hpos, 639);
    check("h639_visible", visible, 1);
    check("h639_hblank", hblank, 0);
    scan(1, 1'b0, 639, 800, 8);
    check("h640_hpos", hpos, 640);
    check("h640_visible", visible, 0);
    check("h640_hblank", hblank, 1);
    scan(5760, 1'b0, 640, 800, 8);
    check("first_frame_start", frame_start, 1);
    check("first_frame_hpos_trk", s_hbad, 0);

    // One full default frame
    scan(6400, 1'b0, 0, 800, 8);
    check("def_hpos_trk", s_hbad, 0);
    check("def_vpos_trk", s_vbad, 0);
    check("def_line_starts", s_ls, 8);
    check("def_line_period", s_ls_per, 800);
    check("def_frame_starts", s_fs, 1);
    check("def_frame_start_t", s_fs_t, 6400);
    check("def_hsync_cycles", s_hs, 768);
    check("def_hsync_first", s_first_hs, 656);
    check("def_vsync_cycles", s_vs, 800);
    check("def_vsync_first", s_first_vs, 4000);
    check("def_visible_cycles", s_vis, 2560);
    check("neg_hsync_low", s_hsn_lo, 768);
    check("neg_vsync_low", s_vsn_lo, 800);

    // pix_en on every other clock
    scan(12800, 1'b1, 0, 800, 8);
    check("tog_hpos_trk", s_hbad, 0);
    check("tog_line_starts", s_ls, 8);
    check("tog_line_period", s_ls_per, 1600);
    check("tog_frame_start_t", s_fs_t, 12799);
    check("tog_hsync_cycles", s_hs, 1536);
    check("tog_hsync_first", s_first_hs, 1311);

    // Mid-frame reprogram to 8x6
    scan(1000, 1'b0, 0, 800, 8);
    set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("load_cfg_ready", cfg_ready, 0);
    check("load_cfg_err", cfg_err, 0);
    scan(5398, 1'b0, 1001, 800, 8);
    check("old_frame_hpos_trk", s_hbad, 0);
    check("old_frame_vpos_trk", s_vbad, 0);
    check("pending_ready_low", s_rdy_lo, 5398);
    check("old_last_hpos", hpos, 799);
    check("old_last_vpos", vpos, 7);
    scan(1, 1'b0, 6399, 800, 8);
    check("apply_frame_start", frame_start, 1);
    check("apply_cfg_ready", cfg_ready, 1);
    check("apply_pos", {22'd0, hpos}, 0);
    check("apply_visible", visible, 1);
    scan(48, 1'b0, 0, 8, 6);
    check("new_hpos_trk", s_hbad, 0);
    check("new_vpos_trk", s_vbad, 0);
    check("new_line_starts", s_ls, 6);
    check("new_line_period", s_ls_per, 8);
    check("new_frame_start_t", s_fs_t, 48);
    check("new_hsync_cycles", s_hs, 12);
    check("new_hsync_first", s_first_hs, 5);
    check("new_vsync_first", s_first_vs, 32);
    check("new_visible_cycles", s_vis, 12);

    // Rejected configs
    set_cfg(0, 1, 2, 1, 3, 1, 1, 1);
    cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
    check("rej_hview0_err", cfg_err, 1);
    check("rej_hview0_ready", cfg_ready, 1);
    tick();
    check("rej_err_pulse", cfg_err, 0);
    set_cfg(1000, 10, 10, 5, 3, 1, 1, 1);
    cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
    check("rej_hsum1025_err", cfg_err, 1);
    check("rej_hsum1025_ready", cfg_ready, 1);
    tick();
    set_cfg(4, 1, 2, 1, 3, 1, 0, 1);
    cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
    check("rej_vsync0_err", cfg_err, 1);
    tick();
    check("rej_vsync0_clear", cfg_err, 0);
    scan(96, 1'b0, 6, 8, 6);
    check("rej_timing_trk", s_hbad + s_vbad, 0);
    check("rej_frame_starts", s_fs, 2);
    check("rej_ready_low", s_rdy_lo, 0);

    // Pending config (H sum exactly 1024) discarded by reset
    set_cfg(1000, 10, 10, 4, 3, 1, 1, 1);
    cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;
    check("sum1024_accept", cfg_ready, 0);
    check("sum1024_no_err", cfg_err, 0);
    scan(6, 1'b0, 7, 8, 6);
    check("pre_rst_hsync", hsync, 1);
    check("pre_rst_ready", cfg_ready, 0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_hpos", hpos, 0);
    check("async_rst_vpos", vpos, 0);
    check("async_rst_hsync", hsync, 0);
    check("async_rst_hsync_neg", n_hsync, 1);
    check("async_rst_visible", visible, 1);
    check("async_rst_ready", cfg_ready, 1);
    tick(); tick();
    reset = 1'b1;
    scan(12800, 1'b0, 0, 800, 8);
    check("post_rst_trk", s_hbad + s_vbad, 0);
    check("post_rst_line_starts", s_ls, 16);
    check("post_rst_frame_starts", s_fs, 2);
    check("post_rst_hsync_cycles", s_hs, 1536);
    check("post_rst_ready_low", s_rdy_lo, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
